// File: rtl/epp_bram_bridge.sv
// EPP host port to banked BRAM bridge: holds an address/bank/autoinc register set
// and turns each synchronized host strobe into one register or BRAM access.
module epp_bram_bridge #(
  parameter int ADDR_W = 12,
  parameter int NBANK  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stb_data,
  input  logic                 ctrl_wr,
  input  logic [7:0]           epp_in,
  input  logic [7:0]           epp_addr_in,
  output logic [7:0]           epp_out,
  output logic                 eppwait,
  output logic [ADDR_W-1:0]    bram_addr,
  input  logic [8*NBANK-1:0]   bram_in,
  output logic [7:0]           bram_out,
  output logic [NBANK-1:0]     bram_we
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DECODE  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [1:0] SEL_DATA    = 2'd0;
  localparam logic [1:0] SEL_ADDR_LO = 2'd1;
  localparam logic [1:0] SEL_ADDR_HI = 2'd2;
  localparam logic [1:0] SEL_CTRL    = 2'd3;

  localparam int HI_W = ADDR_W - 8;

  logic [1:0]        state;
  logic              s_meta, s_sync, s_prev;
  logic              armed;
  logic [1:0]        settle;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bank;
  logic              autoinc;
  logic              acc_data;
  logic [1:0]        sel;
  logic              start;
  logic [7:0]        rd_byte;
  logic [7:0]        reg_rd;
  logic              unused_bits;

  assign sel         = epp_addr_in[7:6];
  assign unused_bits = ^epp_addr_in[5:0];
  assign start       = armed && s_prev && !s_sync;

  // The edge detector only arms once the synchronizer holds a genuinely sampled
  // high strobe, so a strobe already low when reset drops cannot fake a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_prev <= 1'b1;
      armed  <= 1'b0;
      settle <= 2'd0;
    end else begin
      s_meta <= stb_data;
      s_sync <= s_meta;
      s_prev <= s_sync;
      if (settle != 2'd2)
        settle <= settle + 2'd1;
      if (settle == 2'd2 && s_sync)
        armed <= 1'b1;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NBANK; k++)
      if (int'(bank) == k)
        rd_byte = bram_in[8*k +: 8];
  end

  always_comb begin
    reg_rd = 8'h00;
    case (sel)
      SEL_ADDR_LO: reg_rd = addr[7:0];
      SEL_ADDR_HI: reg_rd = 8'(addr[ADDR_W-1:8]);
      SEL_CTRL:    reg_rd = {autoinc, 5'b00000, bank};
      default:     reg_rd = 8'h00;
    endcase
  end

  // Out-of-range banks simply match no bit; reset gates the pulse off at once.
  always_comb begin
    bram_we = '0;
    if (!rst && state == DECODE && !ctrl_wr && sel == SEL_DATA)
      for (int k = 0; k < NBANK; k++)
        bram_we[k] = (int'(bank) == k);
  end

  // Write data is captured on the start edge so bram_out is already valid
  // during the single DECODE cycle in which the write enable is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      bank      <= 2'd0;
      autoinc   <= 1'b0;
      acc_data  <= 1'b0;
      epp_out   <= 8'h00;
      eppwait   <= 1'b0;
      bram_out  <= 8'h00;
      bram_addr <= '0;
    end else begin
      bram_addr <= addr;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DECODE;
            bram_out <= epp_in;
          end
        end
        DECODE: begin
          acc_data <= (sel == SEL_DATA);
          if (sel == SEL_DATA && ctrl_wr) begin
            state <= RD_WAIT;
          end else begin
            state   <= DONE;
            eppwait <= 1'b1;
            if (ctrl_wr) begin
              epp_out <= reg_rd;
            end else if (sel == SEL_ADDR_LO) begin
              addr[7:0] <= epp_in;
            end else if (sel == SEL_ADDR_HI) begin
              addr[ADDR_W-1:8] <= epp_in[HI_W-1:0];
            end else if (sel == SEL_CTRL) begin
              bank    <= epp_in[1:0];
              autoinc <= epp_in[7];
            end
          end
        end
        RD_WAIT: begin
          epp_out <= rd_byte;
          state   <= DONE;
          eppwait <= 1'b1;
        end
        DONE: begin
          // Release is tested as a level so an early release still finishes here.
          if (s_sync) begin
            state   <= IDLE;
            eppwait <= 1'b0;
            if (acc_data && autoinc)
              addr <= addr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
